parking_gate_controller: RTL and testbench

- Upstream stage of the parking occupancy counter; one instance drives the entry gate and the exit gate.
- Debounces raw gate sensor requests and checks the counter's space flags before admitting a car.
- Operates the barrier outputs, then emits one clean car_entered / car_exited pulse per car, with a stable uni/free tag. The counter registers a car on the falling edge of each pulse.

---
 rtl/parking_pkg.sv | 29 ++
 rtl/gate_fsm.sv | 131 +++++++++++++
 rtl/parking_gate_controller.sv | 122 ++++++++++++
 tb/tb_parking_gate_controller.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared state type, default timing and tag encoding for the
// parking gate controller and its per-gate FSM.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        OPEN,
        PULSE,
        SETTLE,
        DENY,
        RELEASE
    } gate_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_OPEN_CYCLES     = 8;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;
    localparam int unsigned DEF_SETTLE_CYCLES   = 2;
    localparam int unsigned DEF_CNT_W           = 16;

    // Car class tag carried alongside car_entered / car_exited.
    localparam logic TAG_UNI  = 1'b1;
    localparam logic TAG_FREE = 1'b0;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_fsm.sv
// gate_fsm: one gate's request debounce, admit/deny decision, barrier and
// car-pulse sequencing, and the class tag latched at acceptance.
module gate_fsm
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned OPEN_CYCLES     = DEF_OPEN_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic is_uni_i,
    input  logic space_ok_i,
    output logic gate_open_o,
    output logic car_o,
    output logic tag_o,
    output logic deny_o,
    output logic pulse_start_o,
    output logic deny_start_o
);

    localparam int unsigned MAX_CYCLES =
        max2(max2(DEBOUNCE_CYCLES, OPEN_CYCLES), max2(PULSE_CYCLES, SETTLE_CYCLES));
    localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LAST   = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    gate_state_t   state_q, state_d;
    logic [CW-1:0] dbc_q, dbc_d;
    logic [CW-1:0] ph_q, ph_d;
    logic          tag_q, tag_d;

    // State, debounce count, phase count and tag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dbc_q   <= '0;
            ph_q    <= '0;
            tag_q   <= TAG_FREE;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
            ph_q    <= ph_d;
            tag_q   <= tag_d;
        end
    end

    // Next state and Moore outputs; the phase counter restarts on every state change.
    always_comb begin
        state_d       = state_q;
        dbc_d         = dbc_q;
        ph_d          = ph_q;
        tag_d         = tag_q;
        gate_open_o   = 1'b0;
        car_o         = 1'b0;
        deny_o        = 1'b0;
        pulse_start_o = 1'b0;
        deny_start_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!req_i) begin
                    dbc_d = '0;
                end else if (dbc_q == DEB_LAST) begin
                    state_d = DECIDE;
                    dbc_d   = '0;
                    tag_d   = is_uni_i;
                end else begin
                    dbc_d = dbc_q + 1'b1;
                end
            end
            DECIDE: begin
                ph_d = '0;
                if (space_ok_i) begin
                    state_d = OPEN;
                end else begin
                    state_d      = DENY;
                    deny_start_o = 1'b1;
                end
            end
            OPEN: begin
                gate_open_o = 1'b1;
                if (ph_q == OPEN_LAST) begin
                    state_d       = PULSE;
                    ph_d          = '0;
                    pulse_start_o = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            PULSE: begin
                car_o = 1'b1;
                if (ph_q == PULSE_LAST) begin
                    state_d = SETTLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SETTLE: begin
                if (ph_q == SETTLE_LAST) begin
                    state_d = RELEASE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DENY: begin
                deny_o  = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                dbc_d   = '0;
                ph_d    = '0;
            end
        endcase
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entry and exit gate sequencing in front of the
// occupancy counter. Optional GATE_STATS_EN adds saturating admitted / denied /
// exited statistics counters of CNT_W bits.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned OPEN_CYCLES     = DEF_OPEN_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic entry_req,
    input  logic entry_is_uni,
    input  logic exit_req,
    input  logic exit_is_uni,
    input  logic uni_is_vacated_space,
    input  logic free_is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied
`ifdef GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] admitted_cnt,
    output logic [CNT_W-1:0] denied_cnt,
    output logic [CNT_W-1:0] exited_cnt
`endif
);

    logic entry_space_ok;
    logic entry_pulse_start;
    logic entry_deny_start;
    logic exit_pulse_start;
    logic exit_deny_unused;
    logic exit_deny_start_unused;

    // The latched tag is already valid in DECIDE, so it selects the class flag.
    assign entry_space_ok = (is_uni_car_entered == TAG_UNI) ? uni_is_vacated_space
                                                            : free_is_vacated_space;

    gate_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .PULSE_CYCLES   (PULSE_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES)
    ) u_entry (
        .clk_i        (clock),
        .rst_ni       (reset),
        .req_i        (entry_req),
        .is_uni_i     (entry_is_uni),
        .space_ok_i   (entry_space_ok),
        .gate_open_o  (entry_gate_open),
        .car_o        (car_entered),
        .tag_o        (is_uni_car_entered),
        .deny_o       (entry_denied),
        .pulse_start_o(entry_pulse_start),
        .deny_start_o (entry_deny_start)
    );

    gate_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .PULSE_CYCLES   (PULSE_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES)
    ) u_exit (
        .clk_i        (clock),
        .rst_ni       (reset),
        .req_i        (exit_req),
        .is_uni_i     (exit_is_uni),
        .space_ok_i   (1'b1),
        .gate_open_o  (exit_gate_open),
        .car_o        (car_exited),
        .tag_o        (is_uni_car_exited),
        .deny_o       (exit_deny_unused),
        .pulse_start_o(exit_pulse_start),
        .deny_start_o (exit_deny_start_unused)
    );

`ifdef GATE_STATS_EN
    logic [CNT_W-1:0] admitted_q, admitted_d;
    logic [CNT_W-1:0] denied_q, denied_d;
    logic [CNT_W-1:0] exited_q, exited_d;

    // Saturating increments on the PULSE / DENY entry strobes.
    always_comb begin
        admitted_d = admitted_q;
        denied_d   = denied_q;
        exited_d   = exited_q;
        if (entry_pulse_start && (admitted_q != '1)) admitted_d = admitted_q + 1'b1;
        if (entry_deny_start  && (denied_q   != '1)) denied_d   = denied_q + 1'b1;
        if (exit_pulse_start  && (exited_q   != '1)) exited_d   = exited_q + 1'b1;
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            admitted_q <= '0;
            denied_q   <= '0;
            exited_q   <= '0;
        end else begin
            admitted_q <= admitted_d;
            denied_q   <= denied_d;
            exited_q   <= exited_d;
        end
    end

    assign admitted_cnt = admitted_q;
    assign denied_cnt   = denied_q;
    assign exited_cnt   = exited_q;
`else
    localparam int unsigned cnt_w_unused = CNT_W;
    logic stats_unused;
    assign stats_unused = ^{entry_pulse_start, entry_deny_start, exit_pulse_start};
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed and randomized scenarios checked cycle by
// cycle against an interval-based timeline model of each gate.
module tb_parking_gate_controller;

    localparam int DEB  = 4;
    localparam int OPN  = 8;
    localparam int PUL  = 2;
    localparam int SET  = 2;
    localparam int MAXN = 700;
    localparam int PAD  = 64;

    typedef struct packed {
        bit ereq;
        bit euni;
        bit xreq;
        bit xuni;
        bit spu;
        bit spf;
    } stim_t;

    // Output vector bit order: {egate, ecar, etag, edeny, xgate, xcar, xtag}
    stim_t      stim [MAXN+PAD];
    logic [6:0] expv [MAXN+PAD];
    logic [6:0] obs  [MAXN+PAD];

    int checks = 0;
    int passes = 0;
    int admits = 0;
    int denies = 0;
    int exits  = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic entry_req = 1'b0, entry_is_uni = 1'b0, exit_req = 1'b0, exit_is_uni = 1'b0;
    logic uni_is_vacated_space = 1'b0, free_is_vacated_space = 1'b0;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_gate_open, exit_gate_open, entry_denied;
`ifdef GATE_STATS_EN
    logic [1:0] admitted_cnt, denied_cnt, exited_cnt;
`endif

    always #5 clock = ~clock;

    parking_gate_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .OPEN_CYCLES    (OPN),
        .PULSE_CYCLES   (PUL),
        .SETTLE_CYCLES  (SET),
        .CNT_W          (2)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .entry_req            (entry_req),
        .entry_is_uni         (entry_is_uni),
        .exit_req             (exit_req),
        .exit_is_uni          (exit_is_uni),
        .uni_is_vacated_space (uni_is_vacated_space),
        .free_is_vacated_space(free_is_vacated_space),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_gate_open      (entry_gate_open),
        .exit_gate_open       (exit_gate_open),
        .entry_denied         (entry_denied)
`ifdef GATE_STATS_EN
        ,
        .admitted_cnt         (admitted_cnt),
        .denied_cnt           (denied_cnt),
        .exited_cnt           (exited_cnt)
`endif
    );

    function automatic logic [6:0] outs();
        return {entry_gate_open, car_entered, is_uni_car_entered, entry_denied,
                exit_gate_open, car_exited, is_uni_car_exited};
    endfunction

    function automatic void clear_stim();
        for (int i = 0; i < MAXN + PAD; i++) stim[i] = '0;
        admits = 0;
        denies = 0;
        exits  = 0;
    endfunction

    // Timeline model: find each run of DEB high samples while idle, then lay out
    // the decision, barrier, pulse and settle intervals, then wait for a low sample.
    function automatic void model_side(input bit ex, input int n);
        int gp, cp, tp, c, run, dec, r;
        bit tag, ok;
        gp = ex ? 2 : 6;
        cp = ex ? 1 : 5;
        tp = ex ? 0 : 4;
        for (int i = 0; i < MAXN + PAD; i++) begin
            expv[i][gp] = 1'b0;
            expv[i][cp] = 1'b0;
            expv[i][tp] = 1'b0;
            if (!ex) expv[i][3] = 1'b0;
        end
        c = 1;
        run = 0;
        tag = 1'b0;
        while (c <= n) begin
            expv[c][tp] = tag;
            run = (ex ? stim[c].xreq : stim[c].ereq) ? run + 1 : 0;
            c++;
            if (run == DEB) begin
                dec = c;
                tag = ex ? stim[c-1].xuni : stim[c-1].euni;
                ok  = ex ? 1'b1 : (tag ? stim[dec].spu : stim[dec].spf);
                if (ok) begin
                    for (int k = 1; k <= OPN; k++) expv[dec+k][gp] = 1'b1;
                    for (int k = 1; k <= PUL; k++) expv[dec+OPN+k][cp] = 1'b1;
                    r = dec + OPN + PUL + SET + 1;
                    if (ex) exits++;
                    else admits++;
                end else begin
                    expv[dec+1][3] = 1'b1;
                    r = dec + 2;
                    denies++;
                end
                for (int k = dec; k < r; k++) expv[k][tp] = tag;
                c = r;
                while (c <= n && (ex ? stim[c].xreq : stim[c].ereq)) begin
                    expv[c][tp] = tag;
                    c++;
                end
                if (c <= n) expv[c][tp] = tag;
                c++;
                run = 0;
            end
        end
    endfunction

    function automatic void build(input int n);
        model_side(1'b0, n);
        model_side(1'b1, n);
    endfunction

    // Called at a falling edge: observe cycle c, drive cycle c inputs, advance.
    task automatic play(input int n);
        for (int c = 1; c <= n; c++) begin
            obs[c] = outs();
            entry_req             = stim[c].ereq;
            entry_is_uni          = stim[c].euni;
            exit_req              = stim[c].xreq;
            exit_is_uni           = stim[c].xuni;
            uni_is_vacated_space  = stim[c].spu;
            free_is_vacated_space = stim[c].spf;
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        entry_req = 1'b0;
        exit_req = 1'b0;
        entry_is_uni = 1'b0;
        exit_is_uni = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (outs() !== 7'b0) $display("FAIL reset_outputs: got %b expected %b", outs(), 7'b0);
        else passes++;
    endtask

    task automatic test_entry_uni();
        int ncar;
        logic [6:0] got;
        clear_stim();
        for (int c = 1; c <= 40; c++) begin
            stim[c].ereq = (c <= 20) || (c >= 23);
            stim[c].euni = 1'b1;
            stim[c].spu  = 1'b1;
        end
        build(40);
        do_reset();
        play(40);
        for (int c = 1; c <= 40; c++) begin
            checks++;
            if (obs[c] !== expv[c]) $display("FAIL entry_uni cycle %0d: got %b expected %b", c, obs[c], expv[c]);
            else passes++;
        end
        got = {obs[5][6], obs[6][6], obs[13][6], obs[14][6], obs[14][5], obs[15][5], obs[16][5]};
        checks++;
        if (got !== 7'b0110110) $display("FAIL entry_uni_timing: got %b expected %b", got, 7'b0110110);
        else passes++;
        ncar = 0;
        for (int c = 1; c <= 22; c++) ncar += int'(obs[c][5]);
        checks++;
        if (ncar !== PUL) $display("FAIL entry_uni_single_pulse: got %0d expected %0d", ncar, PUL);
        else passes++;
        checks++;
        if ({obs[36][5], obs[37][5], obs[36][4]} !== 3'b111)
            $display("FAIL entry_uni_second_car: got %b expected %b", {obs[36][5], obs[37][5], obs[36][4]}, 3'b111);
        else passes++;
    endtask

    task automatic test_deny();
        logic [19:0] dv;
        int nopen;
        clear_stim();
        for (int c = 1; c <= 20; c++) begin
            stim[c].ereq = (c <= 8);
            stim[c].spu  = 1'b1;
        end
        build(20);
        do_reset();
        play(20);
        dv = '0;
        nopen = 0;
        for (int c = 1; c <= 20; c++) begin
            dv[c-1] = obs[c][3];
            nopen += int'(obs[c][6]) + int'(obs[c][5]);
            checks++;
            if (obs[c] !== expv[c]) $display("FAIL deny cycle %0d: got %b expected %b", c, obs[c], expv[c]);
            else passes++;
        end
        checks++;
        if (dv !== 20'h00020) $display("FAIL deny_pulse: got %h expected %h", dv, 20'h00020);
        else passes++;
        checks++;
        if (nopen !== 0) $display("FAIL deny_no_gate: got %0d expected 0", nopen);
        else passes++;
    endtask

    task automatic test_bounce();
        int ncar;
        clear_stim();
        for (int c = 1; c <= 30; c++) begin
            stim[c].ereq = (c <= 3) || (c >= 5 && c <= 8);
            stim[c].euni = 1'b1;
            stim[c].spu  = 1'b1;
        end
        build(30);
        do_reset();
        play(30);
        ncar = 0;
        for (int c = 1; c <= 30; c++) begin
            ncar += int'(obs[c][5]);
            checks++;
            if (obs[c] !== expv[c]) $display("FAIL bounce cycle %0d: got %b expected %b", c, obs[c], expv[c]);
            else passes++;
        end
        checks++;
        if ({obs[9][6], obs[10][6]} !== 2'b01)
            $display("FAIL bounce_latency: got %b expected %b", {obs[9][6], obs[10][6]}, 2'b01);
        else passes++;
        checks++;
        if (ncar !== PUL) $display("FAIL bounce_one_accept: got %0d expected %0d", ncar, PUL);
        else passes++;
    endtask

    task automatic test_back_to_back();
        clear_stim();
        for (int c = 1; c <= 24; c++) begin
            stim[c].ereq = (c <= 20);
            stim[c].xreq = (c <= 20);
            stim[c].euni = 1'b1;
            stim[c].xuni = 1'b0;
            stim[c].spu  = 1'b1;
        end
        build(24);
        do_reset();
        play(24);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (obs[c] !== expv[c]) $display("FAIL concurrent cycle %0d: got %b expected %b", c, obs[c], expv[c]);
            else passes++;
        end
        checks++;
        if ({obs[5][6], obs[5][2], obs[6][6], obs[6][2]} !== 4'b0011)
            $display("FAIL concurrent_open: got %b expected %b", {obs[5][6], obs[5][2], obs[6][6], obs[6][2]}, 4'b0011);
        else passes++;
        checks++;
        if (obs[14] !== 7'b0110010 || obs[15] !== 7'b0110010)
            $display("FAIL concurrent_pulse: got %b %b expected %b", obs[14], obs[15], 7'b0110010);
        else passes++;
    endtask

    task automatic test_reset_open();
        clear_stim();
        for (int c = 1; c <= 40; c++) begin
            stim[c].ereq = 1'b1;
            stim[c].euni = 1'b1;
            stim[c].spu  = 1'b1;
        end
        build(11);
        do_reset();
        play(10);
        checks++;
        if (outs() !== expv[11]) $display("FAIL reset_open_before: got %b expected %b", outs(), expv[11]);
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 7'b0) $display("FAIL reset_async: got %b expected %b", outs(), 7'b0);
        else passes++;
        @(negedge clock);
        reset = 1'b1;
        build(16);
        play(16);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (obs[c] !== expv[c]) $display("FAIL reset_rerun cycle %0d: got %b expected %b", c, obs[c], expv[c]);
            else passes++;
        end
        checks++;
        if ({obs[5][6], obs[6][6]} !== 2'b01)
            $display("FAIL reset_full_debounce: got %b expected %b", {obs[5][6], obs[6][6]}, 2'b01);
        else passes++;
    endtask

    task automatic test_random();
        int c, len;
        bit hi;
        int nbad;
        clear_stim();
        for (int s = 0; s < 2; s++) begin
            c = 1;
            hi = 1'b0;
            while (c <= 600) begin
                len = hi ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 25));
                hi = ~hi;
                for (int k = 0; k < len && c <= 600; k++) begin
                    if (s == 0) stim[c].ereq = hi;
                    else stim[c].xreq = hi;
                    c++;
                end
            end
        end
        for (int i = 1; i <= 600; i++) begin
            stim[i].euni = 1'($urandom_range(0, 1));
            stim[i].xuni = 1'($urandom_range(0, 1));
            stim[i].spu  = 1'($urandom_range(0, 1));
            stim[i].spf  = 1'($urandom_range(0, 1));
        end
        build(600);
        do_reset();
        play(600);
        nbad = 0;
        for (int i = 1; i <= 600; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
                nbad++;
                if (nbad <= 20) $display("FAIL random cycle %0d: got %b expected %b", i, obs[i], expv[i]);
            end else passes++;
        end
    endtask

`ifdef GATE_STATS_EN
    task automatic test_stats();
        int exp_adm;
        clear_stim();
        for (int s = 0; s < 6; s++) begin
            for (int k = 1; k <= 20; k++) begin
                stim[s*20+k].ereq = (k <= 4);
                stim[s*20+k].euni = (s < 5);
                stim[s*20+k].xreq = (s == 0) && (k <= 4);
                stim[s*20+k].spu  = 1'b1;
                stim[s*20+k].spf  = 1'b0;
            end
        end
        build(130);
        do_reset();
        play(130);
        exp_adm = (admits > 3) ? 3 : admits;
        checks++;
        if (admitted_cnt !== 2'(exp_adm)) $display("FAIL stats_admitted: got %0d expected %0d", admitted_cnt, exp_adm);
        else passes++;
        checks++;
        if (denied_cnt !== 2'(denies)) $display("FAIL stats_denied: got %0d expected %0d", denied_cnt, denies);
        else passes++;
        checks++;
        if (exited_cnt !== 2'(exits)) $display("FAIL stats_exited: got %0d expected %0d", exited_cnt, exits);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_entry_uni();
        test_deny();
        test_bounce();
        test_back_to_back();
        test_reset_open();
        test_random();
`ifdef GATE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
